pkt_attr_resolver: RTL and testbench
====================================

Name: pkt_attr_resolver

Overview:
- Per-packet result arbiter that sits between the network-protocol-combination parsers (TCP/UDP/IP/no-hit) and the rule/statistics stage of the monitoring output port lookup.
- Every parser pulses its own `pkt_valid` / `pkt_attributes` at a different cycle for the same packet. This block frames each packet from the stream's `in_valid` / `in_tlast`, collects all parser hits inside that packet's window, and selects exactly one attribute word per packet by protocol-ID priority.
- The winner is pushed into a small first-word-fall-through (FWFT) FIFO that drains through a valid/ready handshake.

Parameters:
- `NUM_PARSERS`, 4: number of parser result inputs; index 0 is the lowest index.
- `ATTRIBUTE_DATA_WIDTH`, 135: width of one attribute word.
- `PRTCL_ID_OFFSET`, 125: LSB of the protocol-ID field inside an attribute word.
- `PRTCL_ID_WIDTH`, 2: width of the protocol-ID field.
- `SETTLE_CYCLES`, 2: cycles waited after the tlast beat for late parser pulses; legal range 1..3.
- `FIFO_ADDR_WIDTH`, 2: output FIFO depth is 2^`FIFO_ADDR_WIDTH` (4).
- `DROP_CNT_WIDTH`, 32: width of the drop and no-hit counters.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: stream beat valid, the same delayed stream the parsers observe.
- `in_tlast` in 1: last beat of packet, qualified by `in_valid`.
- `parser_valid` in `NUM_PARSERS`: one-cycle result pulse per parser.
- `parser_attributes` in `NUM_PARSERS*ATTRIBUTE_DATA_WIDTH`: parser i occupies slice [i*W +: W].
- `out_valid` out 1: FIFO not empty.
- `out_attributes` out `ATTRIBUTE_DATA_WIDTH`: FIFO head word.
- `out_ready` in 1: consumer pop; a pop occurs when `out_valid && out_ready`.
- `drop_count` out `DROP_CNT_WIDTH`: winners lost because the FIFO was full; saturating.
- `nohit_count` out `DROP_CNT_WIDTH`: packets that closed with no parser hit; saturating.

Behaviour:
- Clocking and reset:
  - One clock: `clk`.
  - Reset is synchronous and active-high on port `reset`.
  - On reset: state returns to IDLE; the hit-capture registers, `start_pending`, the settle counter, the FIFO pointers, `out_valid`, `drop_count` and `nohit_count` all go to 0. `out_attributes` is don't-care while `out_valid` = 0.
  - Reset mid-packet discards the in-flight packet with no commit and no counter change.
- States:
  - IDLE:
    - `in_valid && !in_tlast` -> COLLECT.
    - `in_valid && in_tlast` (single-beat packet) -> SETTLE, with the settle counter loaded to `SETTLE_CYCLES`.
  - COLLECT:
    - `in_valid && in_tlast` -> SETTLE, counter loaded to `SETTLE_CYCLES`.
  - SETTLE:
    - Counter decrements each cycle; at 1 -> COMMIT.
  - COMMIT (1 cycle):
    - Push the winner (or count a no-hit), then clear the capture registers.
    - Go to COLLECT if `start_pending` (cleared there), else to IDLE.
    - If `in_valid` is seen in the COMMIT cycle itself, treat it as a packet start (COLLECT, or SETTLE if that beat is also tlast).
- Capture:
  - In IDLE-with-start, COLLECT and SETTLE, each `parser_valid[i]` pulse sets `hit[i]` and stores that slice into `attr[i]`.
  - A second pulse from the same parser in the same window is ignored; the first is retained.
  - Pulses arriving in IDLE without `in_valid`, or in COMMIT, are discarded.
- Next-packet start:
  - `in_valid` seen during SETTLE sets `start_pending`, and that beat's `in_tlast` is recorded.
  - A pending start whose first beat was also tlast goes COMMIT -> SETTLE directly.
- Selection (combinational over the `hit` / `attr` registers):
  - The winner is the set `hit[i]` whose protocol-ID field `attr[i][PRTCL_ID_OFFSET +: PRTCL_ID_WIDTH]` is numerically largest.
  - Ties go to the lowest index.
  - No `hit` bit set -> `nohit_count` += 1 (saturating), nothing is pushed.
- FIFO:
  - FWFT: `out_attributes` shows the head word whenever `out_valid` = 1.
  - Push at COMMIT when not full, or when full and a pop occurs in the same cycle.
  - Push when full with no pop -> word dropped, `drop_count` += 1 (saturating at all-ones).
  - Simultaneous push and pop when empty: the pushed word appears with `out_valid` = 1 on the next cycle; `out_valid` stays 0 in the current cycle.
  - Pointers wrap modulo depth; full/empty are resolved with an extra pointer MSB.
- Latency: from the tlast beat to `out_valid` rising (FIFO empty, hit present) is `SETTLE_CYCLES` + 2 cycles.
  - Within that: tlast cycle -> SETTLE (`SETTLE_CYCLES` cycles) -> COMMIT -> FIFO registered.
- Throughput: at most one commit per packet. Packets of at least 2 beats sustain line rate; back-to-back single-beat packets shorter than `SETTLE_CYCLES` + 1 cycles are out of contract.

Test Plan:
1. **Single hit.** 4-beat packet; `parser_valid[3]` pulses on beat 3 with protocol ID 0 and the bytes field = 0x0040 -> exactly one word out, equal to parser 3's slice; `out_valid` rises 4 cycles after the tlast beat (`SETTLE_CYCLES` = 2).
2. **Priority and tie.** Parsers 0, 1, 2 all hit, with protocol IDs 1, 3, 3 -> parser 1's word is output. A second packet with IDs 2, 2, 0 -> parser 0's word is output.
3. **Late pulse.** `parser_valid[2]` arrives 2 cycles after tlast (inside SETTLE) -> it is captured and wins. A pulse arriving 3 cycles after tlast (COMMIT) is ignored -> `nohit_count` = 1.
4. **Back-to-back.** Packet B's first beat arrives on the cycle after A's tlast; each packet has one distinct hit -> two words out in order A, B; nothing dropped and no cross-packet mixing.
5. **FIFO full.** `out_ready` = 0 for 6 hit packets -> 4 words stored, `drop_count` = 2. Then `out_ready` = 1 -> the 4 words drain in arrival order and `out_valid` falls afterwards. Commit on a full FIFO with a same-cycle pop -> accepted, `drop_count` unchanged.
6. **Reset mid-packet.** Pulse `reset` during COLLECT after `parser_valid[1]` -> no output, both counters stay 0; the next packet resolves normally.

Source files
------------

// File: rtl/pkt_attr_resolver.sv
// Per-packet parser result arbiter: frames packets from in_valid/in_tlast, collects
// parser hits in each packet window, picks one attribute word by protocol ID, FWFT FIFO out.
module pkt_attr_resolver #(
  parameter int NUM_PARSERS          = 4,
  parameter int ATTRIBUTE_DATA_WIDTH = 135,
  parameter int PRTCL_ID_OFFSET      = 125,
  parameter int PRTCL_ID_WIDTH       = 2,
  parameter int SETTLE_CYCLES        = 2,
  parameter int FIFO_ADDR_WIDTH      = 2,
  parameter int DROP_CNT_WIDTH       = 32
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  input  logic                                        in_tlast,
  input  logic [NUM_PARSERS-1:0]                      parser_valid,
  input  logic [NUM_PARSERS*ATTRIBUTE_DATA_WIDTH-1:0] parser_attributes,
  output logic                                        out_valid,
  output logic [ATTRIBUTE_DATA_WIDTH-1:0]             out_attributes,
  input  logic                                        out_ready,
  output logic [DROP_CNT_WIDTH-1:0]                   drop_count,
  output logic [DROP_CNT_WIDTH-1:0]                   nohit_count
);

  localparam int W          = ATTRIBUTE_DATA_WIDTH;
  localparam int A          = FIFO_ADDR_WIDTH;
  localparam int FIFO_DEPTH = 1 << FIFO_ADDR_WIDTH;

  localparam logic [1:0]                SETTLE_LOAD = 2'(SETTLE_CYCLES);
  localparam logic [A:0]                PTR_ONE     = (A+1)'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] CNT_ONE     = DROP_CNT_WIDTH'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SETTLE  = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] settle_cnt_reg, settle_cnt_next;
  logic       start_pending_reg, start_pending_next;
  logic       pending_tlast_reg, pending_tlast_next;
  logic       capture_en;
  logic       commit;

  // ---------------------------------------------------------------------------
  // Packet framing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      settle_cnt_reg    <= 2'd0;
      start_pending_reg <= 1'b0;
      pending_tlast_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      settle_cnt_reg    <= settle_cnt_next;
      start_pending_reg <= start_pending_next;
      pending_tlast_reg <= pending_tlast_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    settle_cnt_next    = settle_cnt_reg;
    start_pending_next = start_pending_reg;
    pending_tlast_next = pending_tlast_reg;
    capture_en         = 1'b0;
    commit             = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          capture_en = 1'b1;
          if (in_tlast) begin
            state_next      = SETTLE;
            settle_cnt_next = SETTLE_LOAD;
          end else begin
            state_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        capture_en = 1'b1;
        if (in_valid && in_tlast) begin
          state_next      = SETTLE;
          settle_cnt_next = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        capture_en = 1'b1;
        // Beats of the next packet seen here are remembered, including any tlast,
        // so a short follower packet is not left waiting for a tlast already gone.
        if (in_valid) begin
          start_pending_next = 1'b1;
          pending_tlast_next = pending_tlast_reg | in_tlast;
        end
        if (settle_cnt_reg == 2'd1) begin
          state_next = COMMIT;
        end else begin
          settle_cnt_next = settle_cnt_reg - 2'd1;
        end
      end
      COMMIT: begin
        commit             = 1'b1;
        start_pending_next = 1'b0;
        pending_tlast_next = 1'b0;
        if (start_pending_reg) begin
          if (pending_tlast_reg || (in_valid && in_tlast)) begin
            state_next      = SETTLE;
            settle_cnt_next = SETTLE_LOAD;
          end else begin
            state_next = COLLECT;
          end
        end else if (in_valid) begin
          if (in_tlast) begin
            state_next      = SETTLE;
            settle_cnt_next = SETTLE_LOAD;
          end else begin
            state_next = COLLECT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-parser hit capture: first pulse in a window wins, later ones ignored
  // ---------------------------------------------------------------------------
  logic         hit_reg  [NUM_PARSERS];
  logic [W-1:0] attr_reg [NUM_PARSERS];

  generate
    for (genvar gi = 0; gi < NUM_PARSERS; gi++) begin : g_capture
      always_ff @(posedge clk) begin
        if (reset) begin
          hit_reg[gi] <= 1'b0;
        end else if (commit) begin
          hit_reg[gi] <= 1'b0;
        end else if (capture_en && parser_valid[gi] && !hit_reg[gi]) begin
          hit_reg[gi] <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (capture_en && parser_valid[gi] && !hit_reg[gi]) begin
          attr_reg[gi] <= parser_attributes[gi*W +: W];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Winner selection: largest protocol ID; strict compare keeps lowest index on ties
  // ---------------------------------------------------------------------------
  logic                      any_hit;
  logic [PRTCL_ID_WIDTH-1:0] best_id;
  logic [W-1:0]              win_attr;

  always_comb begin
    any_hit  = 1'b0;
    best_id  = '0;
    win_attr = '0;
    for (int i = 0; i < NUM_PARSERS; i++) begin
      if (hit_reg[i] &&
          (!any_hit || (attr_reg[i][PRTCL_ID_OFFSET +: PRTCL_ID_WIDTH] > best_id))) begin
        any_hit  = 1'b1;
        best_id  = attr_reg[i][PRTCL_ID_OFFSET +: PRTCL_ID_WIDTH];
        win_attr = attr_reg[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FWFT FIFO with extra pointer MSB for full/empty
  // ---------------------------------------------------------------------------
  logic [A:0]   wr_ptr_reg, rd_ptr_reg;
  logic [W-1:0] fifo_mem [FIFO_DEPTH];
  logic         fifo_empty, fifo_full;
  logic         pop, push_req, push, drop;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[A] != rd_ptr_reg[A]) &&
                      (wr_ptr_reg[A-1:0] == rd_ptr_reg[A-1:0]);

  assign out_valid      = !fifo_empty;
  assign out_attributes = fifo_mem[rd_ptr_reg[A-1:0]];

  assign pop      = out_valid && out_ready;
  assign push_req = commit && any_hit;
  // A full FIFO still accepts the winner when the head leaves in the same cycle.
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[A-1:0]] <= win_attr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating drop / no-hit counters
  // ---------------------------------------------------------------------------
  logic [DROP_CNT_WIDTH-1:0] drop_count_reg, nohit_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_reg  <= '0;
      nohit_count_reg <= '0;
    end else begin
      if (drop && (drop_count_reg != CNT_MAX)) begin
        drop_count_reg <= drop_count_reg + CNT_ONE;
      end
      if (commit && !any_hit && (nohit_count_reg != CNT_MAX)) begin
        nohit_count_reg <= nohit_count_reg + CNT_ONE;
      end
    end
  end

  assign drop_count  = drop_count_reg;
  assign nohit_count = nohit_count_reg;

endmodule

// File: tb/tb_pkt_attr_resolver.sv
// Directed bench for pkt_attr_resolver: expected winners queued at stimulus time,
// compared as each word leaves the FIFO.
module tb_pkt_attr_resolver;

  localparam int N = 4;
  localparam int W = 135;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_tlast;
  logic [N-1:0]   parser_valid;
  logic [N*W-1:0] parser_attributes;
  logic           out_valid;
  logic [W-1:0]   out_attributes;
  logic           out_ready;
  logic [31:0]    drop_count;
  logic [31:0]    nohit_count;

  logic [W-1:0] exp_q [$];
  int vectors;
  int miscompares;

  pkt_attr_resolver #(
    .NUM_PARSERS(N),
    .ATTRIBUTE_DATA_WIDTH(W),
    .PRTCL_ID_OFFSET(125),
    .PRTCL_ID_WIDTH(2),
    .SETTLE_CYCLES(2),
    .FIFO_ADDR_WIDTH(2),
    .DROP_CNT_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_tlast(in_tlast),
    .parser_valid(parser_valid),
    .parser_attributes(parser_attributes),
    .out_valid(out_valid),
    .out_attributes(out_attributes),
    .out_ready(out_ready),
    .drop_count(drop_count),
    .nohit_count(nohit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [1:0] id, input logic [15:0] tag);
    logic [W-1:0] a;
    a          = '0;
    a[126:125] = id;
    a[31:16]   = tag;
    a[15:0]    = 16'h0040;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_attr(input int p, input logic [W-1:0] a);
    parser_attributes[p*W +: W] = a;
  endtask

  // One clock: sample the output port mid-cycle, then advance past the next edge.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_out: observed %h expected no word", out_attributes);
      end
      if (exp_q.size() != 0) begin
        vectors--;
        chk("out_word", out_attributes, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic l, input logic [N-1:0] pv);
    in_valid     = v;
    in_tlast     = l;
    parser_valid = pv;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0);
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    reset             = 1'b1;
    in_valid          = 1'b0;
    in_tlast          = 1'b0;
    parser_valid      = '0;
    parser_attributes = '0;
    out_ready         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_drop", W'(drop_count), W'(0));
    chk("rst_nohit", W'(nohit_count), W'(0));
    reset = 1'b0;
    idle(2);

    // Single hit on beat 3, latency from tlast to out_valid
    set_attr(3, mk(2'd0, 16'h0003));
    exp_q.push_back(mk(2'd0, 16'h0003));
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b1000);
    cyc(1, 1, 4'b0000);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("lat_low_%0d", k), W'(out_valid), W'(0));
      cyc(0, 0, 4'b0000);
    end
    chk("lat_high", W'(out_valid), W'(1));
    idle(4);

    // Priority: IDs 1,3,3 -> parser 1
    set_attr(0, mk(2'd1, 16'h0010));
    set_attr(1, mk(2'd3, 16'h0011));
    set_attr(2, mk(2'd3, 16'h0012));
    exp_q.push_back(mk(2'd3, 16'h0011));
    cyc(1, 0, 4'b0001);
    cyc(1, 0, 4'b0010);
    cyc(1, 1, 4'b0100);
    idle(6);

    // Tie: IDs 2,2,0 -> parser 0; a repeat pulse from parser 0 is ignored
    set_attr(0, mk(2'd2, 16'h0020));
    set_attr(1, mk(2'd2, 16'h0021));
    set_attr(2, mk(2'd0, 16'h0022));
    exp_q.push_back(mk(2'd2, 16'h0020));
    cyc(1, 0, 4'b0111);
    set_attr(0, mk(2'd3, 16'h002F));
    cyc(1, 1, 4'b0001);
    idle(6);

    // Late pulse 2 cycles after tlast is captured
    set_attr(2, mk(2'd1, 16'h0030));
    exp_q.push_back(mk(2'd1, 16'h0030));
    cyc(1, 0, 4'b0000);
    cyc(1, 1, 4'b0000);
    cyc(0, 0, 4'b0000);
    cyc(0, 0, 4'b0100);
    idle(5);
    chk("late_nohit0", W'(nohit_count), W'(0));

    // Pulse in the commit cycle is discarded -> no-hit
    cyc(1, 0, 4'b0000);
    cyc(1, 1, 4'b0000);
    cyc(0, 0, 4'b0000);
    cyc(0, 0, 4'b0000);
    cyc(0, 0, 4'b0100);
    idle(5);
    chk("commit_pulse_nohit", W'(nohit_count), W'(1));

    // Pulse in IDLE without in_valid is discarded
    cyc(0, 0, 4'b0010);
    cyc(1, 1, 4'b0000);
    idle(6);
    chk("idle_pulse_nohit", W'(nohit_count), W'(2));

    // Back-to-back: B starts the cycle after A's tlast
    set_attr(0, mk(2'd1, 16'h0040));
    exp_q.push_back(mk(2'd1, 16'h0040));
    exp_q.push_back(mk(2'd1, 16'h0041));
    cyc(1, 0, 4'b0001);
    cyc(1, 1, 4'b0000);
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0000);
    set_attr(1, mk(2'd1, 16'h0041));
    cyc(1, 1, 4'b0010);
    idle(7);

    // Single-beat follower packet arriving during settle
    set_attr(0, mk(2'd2, 16'h0042));
    exp_q.push_back(mk(2'd2, 16'h0042));
    exp_q.push_back(mk(2'd0, 16'h0043));
    cyc(1, 0, 4'b0001);
    cyc(1, 1, 4'b0000);
    cyc(1, 1, 4'b0000);
    cyc(0, 0, 4'b0000);
    cyc(0, 0, 4'b0000);
    set_attr(1, mk(2'd0, 16'h0043));
    cyc(0, 0, 4'b0010);
    idle(7);
    chk("b2b_drop", W'(drop_count), W'(0));
    chk("b2b_nohit", W'(nohit_count), W'(2));

    // FIFO full: 6 packets with no consumer -> 4 kept, 2 dropped
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_attr(3, mk(2'd2, 16'h0050 + 16'(k)));
      if (k < 4) exp_q.push_back(mk(2'd2, 16'h0050 + 16'(k)));
      cyc(1, 0, 4'b1000);
      cyc(1, 1, 4'b0000);
      idle(3);
    end
    idle(2);
    chk("full_drop", W'(drop_count), W'(2));
    chk("full_valid", W'(out_valid), W'(1));

    // Commit on a full FIFO with a same-cycle pop is accepted
    set_attr(3, mk(2'd0, 16'h005A));
    exp_q.push_back(mk(2'd0, 16'h005A));
    cyc(1, 0, 4'b1000);
    cyc(1, 1, 4'b0000);
    cyc(0, 0, 4'b0000);
    cyc(0, 0, 4'b0000);
    out_ready = 1'b1;
    cyc(0, 0, 4'b0000);
    out_ready = 1'b0;
    idle(2);
    chk("full_pop_drop", W'(drop_count), W'(2));

    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("drain_done", W'(exp_q.size()), W'(0));
    idle(1);
    chk("drain_valid_low", W'(out_valid), W'(0));

    // Reset in COLLECT after a hit discards the packet
    set_attr(1, mk(2'd3, 16'h0060));
    cyc(1, 0, 4'b0000);
    cyc(1, 0, 4'b0010);
    reset = 1'b1;
    cyc(0, 0, 4'b0000);
    reset = 1'b0;
    chk("rst_mid_valid", W'(out_valid), W'(0));
    chk("rst_mid_drop", W'(drop_count), W'(0));
    chk("rst_mid_nohit", W'(nohit_count), W'(0));
    set_attr(2, mk(2'd1, 16'h0061));
    exp_q.push_back(mk(2'd1, 16'h0061));
    cyc(1, 0, 4'b0000);
    cyc(1, 1, 4'b0100);
    idle(7);
    chk("post_rst_nohit", W'(nohit_count), W'(0));
    chk("post_rst_drop", W'(drop_count), W'(0));
    chk("sb_empty", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
